serial_add_ctrl: RTL and testbench

Bit-serial add sequencer for the half-adder datapath. It streams two WIDTH-bit operands LSB-first through one 1-bit full-adder cell, built from two half-adder cells plus an OR for carry, over WIDTH clock cycles. It sits between the tt_um top-level pin mapping and the adder cell, and drives a start/busy/done handshake. Trading latency for area lets one adder cell serve wide operands.

---
 rtl/serial_add_ctrl.sv | 155 +++++++++++++++
 tb/tb_serial_add_ctrl.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial adder sequencer, LSB-first, one full-adder cell
// built from two half adders. Ports: clk, rst_n (sync, active-low), ena,
// start, a/b/cin in; busy, done, sum, cout, ovf out.
// Define SERIAL_ADD_OVF_EN to build the signed-overflow register; otherwise ovf=0.
module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;

  logic             s1, c1, bit_s, c2, carry_nx;
  logic [WIDTH-1:0] acc_nx;
  logic             last;
  logic             accept;
  logic             step;

  // one full-adder cell: two half adders plus an OR for carry
  always_comb begin
    s1       = opa_q[0] ^ opb_q[0];
    c1       = opa_q[0] & opb_q[0];
    bit_s    = s1 ^ carry_q;
    c2       = s1 & carry_q;
    carry_nx = c1 | c2;
    acc_nx   = {bit_s, acc_q[WIDTH-1:1]};
  end

  assign last   = (cnt_q == CW'(WIDTH - 1));
  assign accept = ena & start & ((state_q == IDLE) | (state_q == DONE));
  assign step   = ena & (state_q == RUN);

  // state register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      opa_q   <= '0;
      opb_q   <= '0;
      acc_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      acc_q   <= acc_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

  // next-state logic
  always_comb begin
    state_d = state_q;
    if (ena) begin
      unique case (1'b1)
        (state_q == IDLE): state_d = start ? RUN : IDLE;
        (state_q == RUN):  state_d = last ? DONE : RUN;
        (state_q == DONE): state_d = start ? RUN : IDLE;
        default:           state_d = IDLE;
      endcase
    end
  end

  // datapath next values
  always_comb begin
    opa_d   = opa_q;
    opb_d   = opb_q;
    acc_d   = acc_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    if (accept) begin
      opa_d   = a;
      opb_d   = b;
      carry_d = cin;
      cnt_d   = '0;
      acc_d   = '0;
    end else if (step) begin
      opa_d   = opa_q >> 1;
      opb_d   = opb_q >> 1;
      acc_d   = acc_nx;
      carry_d = carry_nx;
      cnt_d   = cnt_q + CW'(1);
      if (last) begin
        sum_d  = acc_nx;
        cout_d = carry_nx;
      end
    end
  end

`ifdef SERIAL_ADD_OVF_EN
  logic ovf_q, ovf_d;

  // on the last step carry_q is the carry into the MSB
  always_comb begin
    ovf_d = ovf_q;
    if (!accept && step && last) begin
      ovf_d = carry_q ^ carry_nx;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign ovf = ovf_q;
`else
  assign ovf = 1'b0;
`endif

  // outputs
  always_comb begin
    busy = (state_q == RUN);
    done = (state_q == DONE);
    sum  = sum_q;
    cout = cout_q;
  end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb_serial_add_ctrl: directed plus randomized bench for serial_add_ctrl,
// checked every cycle against a transaction-level model of the adder.
module tb_serial_add_ctrl;

  localparam int W = 8;
`ifdef SERIAL_ADD_OVF_EN
  localparam bit OVF_ON = 1'b1;
`else
  localparam bit OVF_ON = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         ena = 1'b0;
  logic         start = 1'b0;
  logic         cin = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy, done, cout, ovf;
  logic [W-1:0] sum;

  int vectors = 0;
  int miscompares = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .ena  (ena),
    .start(start),
    .a    (a),
    .b    (b),
    .cin  (cin),
    .busy (busy),
    .done (done),
    .sum  (sum),
    .cout (cout),
    .ovf  (ovf)
  );

  // model: remaining enabled cycles of the current add, plus held result
  int           m_left = 0;
  logic         m_done = 1'b0;
  logic [W-1:0] m_sum = '0;
  logic         m_cout = 1'b0;
  logic         m_ovf = 1'b0;
  logic [W+1:0] p_res = '0;

  function automatic logic [W+1:0] ref_add(input logic [W-1:0] x,
                                           input logic [W-1:0] y,
                                           input logic c);
    logic [W:0] t;
    logic       v;
    t = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
    v = OVF_ON && (x[W-1] == y[W-1]) && (t[W-1] != x[W-1]);
    return {v, t};
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      m_left = 0;
      m_done = 1'b0;
      m_sum  = '0;
      m_cout = 1'b0;
      m_ovf  = 1'b0;
    end else if (ena) begin
      if (m_left > 0) begin
        m_left = m_left - 1;
        if (m_left == 0) begin
          m_done = 1'b1;
          {m_ovf, m_cout, m_sum} = p_res;
        end
      end else begin
        m_done = 1'b0;
        if (start) begin
          m_left = W;
          p_res  = ref_add(a, b, cin);
        end
      end
    end
  end

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("cycle {busy,done,cout,ovf,sum}",
            32'({busy, done, cout, ovf, sum}),
            32'({(m_left > 0), m_done, m_cout, m_ovf, m_sum}));
    end
  end

  // called at the negedge right after the accepting edge
  task automatic wait_done(output int n);
    n = 0;
    while (done !== 1'b1 && n < 60) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic launch(input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic c);
    a     = x;
    b     = y;
    cin   = c;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic do_op(input string nm, input logic [W-1:0] x,
                       input logic [W-1:0] y, input logic c,
                       input logic [W-1:0] es, input logic ec,
                       input logic eo);
    int n;
    @(negedge clk);
    launch(x, y, c);
    check({nm, " busy"}, 32'(busy), 32'(1));
    wait_done(n);
    check({nm, " latency"}, n, W);
    check({nm, " sum"}, 32'(sum), 32'(es));
    check({nm, " cout"}, 32'(cout), 32'(ec));
    check({nm, " ovf"}, 32'(ovf), 32'(eo));
  endtask

  initial begin
    int n;
    ena   = 1'b1;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    check("reset state", 32'({busy, done, cout, ovf, sum}), 32'(0));
    rst_n = 1'b1;

    do_op("0F+01", 8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0);
    do_op("FF+01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
    do_op("FF+00+1", 8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0);
    do_op("7F+01", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, OVF_ON);

    // start during RUN is ignored
    @(negedge clk);
    launch(8'h12, 8'h34, 1'b0);
    repeat (2) @(negedge clk);
    launch(8'hFF, 8'hFF, 1'b0);
    wait_done(n);
    check("ignored start sum", 32'(sum), 32'h46);
    check("ignored start cout", 32'(cout), 32'(0));
    // back-to-back from DONE
    launch(8'hFF, 8'hFF, 1'b0);
    check("b2b busy", 32'(busy), 32'(1));
    wait_done(n);
    check("b2b latency", n, W);
    check("b2b sum", 32'(sum), 32'hFE);
    check("b2b cout", 32'(cout), 32'(1));

    // ena low for 5 cycles mid-RUN
    @(negedge clk);
    launch(8'hAA, 8'h55, 1'b0);
    repeat (2) @(negedge clk);
    ena = 1'b0;
    repeat (5) @(negedge clk);
    ena = 1'b1;
    wait_done(n);
    check("ena stall latency", 7 + n, W + 5);
    check("ena stall sum", 32'(sum), 32'hFF);
    check("ena stall cout", 32'(cout), 32'(0));

    // reset mid-RUN
    @(negedge clk);
    launch(8'h01, 8'h01, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("mid reset", 32'({busy, done, sum}), 32'(0));
    rst_n = 1'b1;
    do_op("03+04 after reset", 8'h03, 8'h04, 1'b0, 8'h07, 1'b0, 1'b0);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      a     = W'($urandom);
      b     = W'($urandom);
      cin   = 1'($urandom);
      start = ($urandom_range(0, 3) == 0);
      ena   = ($urandom_range(0, 7) != 0);
      rst_n = ($urandom_range(0, 299) != 0);
    end
    @(negedge clk);
    start = 1'b0;
    ena   = 1'b1;
    rst_n = 1'b1;
    repeat (20) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
